// File: rtl/cpu_pipe_param.sv
// cpu_pipe_param: 4-stage in-order core (IF, ID, EX, WB) for the 10-bit, 8-opcode ISA, generic data/PC width.
// Latency: an instruction fetched in cycle n writes back in cycle n+3; a taken branch costs 2 bubbles.
// Backpressure: none; memories read combinationally, the pipe never stalls, HALT freezes fetch until reset.
module cpu_pipe_param #(
    parameter int DATA_W = 10,
    parameter int PC_W   = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [9:0]        imem_rdata,
    output logic [3:0]        dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic              dmem_we,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic [DATA_W-1:0] result,
    output logic              result_valid,
    output logic              done,
    output logic [CNT_W-1:0]  retired
);
    typedef enum logic [2:0] {
        OP_LD, OP_ST, OP_ADDI, OP_ADD, OP_GRT, OP_BEQZ, OP_BNE1, OP_HALT
    } op_e;

    // Fetch state
    logic [PC_W-1:0]   pc_q, pc_d;
    logic              halted_q, halted_d;
    // IF/ID
    logic              id_vld_q, id_vld_d;
    logic [9:0]        id_instr_q;
    logic [PC_W-1:0]   id_pc_q;
    logic [DATA_W-1:0] id_a, id_b, id_c0;
    logic              id_halt;
    // ID/EX
    logic              ex_vld_q, ex_vld_d;
    logic [9:0]        ex_instr_q;
    logic [PC_W-1:0]   ex_pc_q;
    logic [DATA_W-1:0] ex_a_q, ex_b_q, ex_c0_q;
    logic [DATA_W-1:0] ex_a, ex_b, ex_c0, ex_val, ex_imm;
    logic [PC_W-1:0]   ex_target;
    logic [2:0]        ex_rd;
    logic              ex_wen, taken;
    op_e               ex_op;
    logic signed [3:0] imm4_s;
    logic signed [6:0] off7_s;
    // EX/WB
    logic              wb_vld_q, wb_wen_q, wb_halt_q;
    logic [2:0]        wb_rd_q;
    logic [DATA_W-1:0] wb_val_q;
    logic              wb_wr;
    // Architectural state and status
    logic [DATA_W-1:0] rf_q [8];
    logic [DATA_W-1:0] result_q;
    logic              done_q;
    logic [CNT_W-1:0]  retired_q;

    // A write-back is real only for a valid writing instruction, never after halt or under reset
    assign wb_wr = wb_vld_q & wb_wen_q & ~done_q & ~reset;

    // ID register read with write-through bypass from this cycle's write-back
    always_comb begin
        id_a  = rf_q[id_instr_q[6:4]];
        id_b  = rf_q[id_instr_q[2:0]];
        id_c0 = rf_q[0];
        if (wb_wr && wb_rd_q == id_instr_q[6:4]) id_a  = wb_val_q;
        if (wb_wr && wb_rd_q == id_instr_q[2:0]) id_b  = wb_val_q;
        if (wb_wr && wb_rd_q == 3'd0)            id_c0 = wb_val_q;
        id_halt = id_vld_q && (id_instr_q[9:7] == 3'b111);
    end

    // EX: operand forwarding from WB, ALU, memory access and branch resolution
    always_comb begin
        ex_op  = op_e'(ex_instr_q[9:7]);
        imm4_s = ex_instr_q[3:0];
        off7_s = ex_instr_q[6:0];
        ex_imm = DATA_W'(imm4_s);
        ex_a   = ex_a_q;
        ex_b   = ex_b_q;
        ex_c0  = ex_c0_q;
        if (wb_wr && wb_rd_q == ex_instr_q[6:4]) ex_a  = wb_val_q;
        if (wb_wr && wb_rd_q == ex_instr_q[2:0]) ex_b  = wb_val_q;
        if (wb_wr && wb_rd_q == 3'd0)            ex_c0 = wb_val_q;
        ex_target = ex_pc_q + PC_W'(1) + PC_W'(off7_s);
        ex_val = '0;
        ex_wen = 1'b0;
        ex_rd  = ex_instr_q[6:4];
        taken  = 1'b0;
        case (ex_op)
            OP_LD: begin
                ex_val = dmem_rdata;
                ex_wen = 1'b1;
            end
            OP_ADDI: begin
                ex_val = ex_a + ex_imm;
                ex_wen = 1'b1;
            end
            OP_ADD: begin
                ex_val = ex_a + ex_b;
                ex_wen = 1'b1;
            end
            OP_GRT: begin
                ex_val = DATA_W'($signed(ex_a) > $signed(ex_b));
                ex_rd  = 3'd0;
                ex_wen = 1'b1;
            end
            OP_BEQZ: taken = ex_vld_q && (ex_c0 == '0);
            OP_BNE1: taken = ex_vld_q && (ex_c0 == DATA_W'(1));
            default: ;
        endcase
    end

    // Fetch control: a taken branch outranks HALT in ID, which in turn freezes the PC for good
    always_comb begin
        pc_d     = pc_q + PC_W'(1);
        halted_d = halted_q;
        id_vld_d = 1'b1;
        ex_vld_d = id_vld_q;
        if (taken) begin
            pc_d     = ex_target;
            id_vld_d = 1'b0;
            ex_vld_d = 1'b0;
        end else if (halted_q || id_halt) begin
            pc_d     = pc_q;
            id_vld_d = 1'b0;
            halted_d = 1'b1;
        end
    end

    // Pipeline stage registers
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q       <= '0;
            halted_q   <= 1'b0;
            id_vld_q   <= 1'b0;
            id_instr_q <= '0;
            id_pc_q    <= '0;
            ex_vld_q   <= 1'b0;
            ex_instr_q <= '0;
            ex_pc_q    <= '0;
            ex_a_q     <= '0;
            ex_b_q     <= '0;
            ex_c0_q    <= '0;
            wb_vld_q   <= 1'b0;
            wb_wen_q   <= 1'b0;
            wb_halt_q  <= 1'b0;
            wb_rd_q    <= '0;
            wb_val_q   <= '0;
        end else begin
            pc_q       <= pc_d;
            halted_q   <= halted_d;
            id_vld_q   <= id_vld_d;
            id_instr_q <= imem_rdata;
            id_pc_q    <= pc_q;
            ex_vld_q   <= ex_vld_d;
            ex_instr_q <= id_instr_q;
            ex_pc_q    <= id_pc_q;
            ex_a_q     <= id_a;
            ex_b_q     <= id_b;
            ex_c0_q    <= id_c0;
            wb_vld_q   <= ex_vld_q & ~done_q;
            wb_wen_q   <= ex_wen;
            wb_halt_q  <= (ex_op == OP_HALT);
            wb_rd_q    <= ex_rd;
            wb_val_q   <= ex_val;
        end
    end

    // Register file R0..R7 (R0 doubles as the compare flag)
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) rf_q[i] <= '0;
        end else if (wb_wr) begin
            rf_q[wb_rd_q] <= wb_val_q;
        end
    end

    // WB status: last result, sticky done once HALT retires, retired count excluding HALT
    always_ff @(posedge clock) begin
        if (reset) begin
            result_q  <= '0;
            done_q    <= 1'b0;
            retired_q <= '0;
        end else begin
            if (wb_wr) result_q <= wb_val_q;
            if (wb_vld_q && wb_halt_q) done_q <= 1'b1;
            if (wb_vld_q && !wb_halt_q && !done_q) retired_q <= retired_q + CNT_W'(1);
        end
    end

    assign imem_addr    = pc_q;
    assign dmem_addr    = ex_instr_q[3:0];
    assign dmem_wdata   = ex_a;
    assign dmem_we      = ex_vld_q & (ex_op == OP_ST) & ~reset & ~done_q;
    assign result_valid = wb_wr;
    assign result       = reset ? '0 : (wb_wr ? wb_val_q : result_q);
    assign done         = done_q;
    assign retired      = retired_q;
endmodule

// File: tb/tb_cpu_pipe_param.sv
// tb_cpu_pipe_param: directed programs against the core, with bench-side instruction/data memories.
// Latency: cycle 0 is the first cycle with reset low; outputs are sampled 1ns after each falling edge.
// Backpressure: none; a second core with a 4-bit PC runs alongside to exercise PC wrap.
`timescale 1ns/1ps
module tb_cpu_pipe_param;
    localparam int DATA_W = 10;
    localparam int PC_W   = 8;
    localparam int CNT_W  = 16;
    localparam logic [9:0] HALT = 10'b111_0000000;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic [PC_W-1:0]   imem_addr;
    logic [9:0]        imem_rdata;
    logic [3:0]        dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic              dmem_we;
    logic [DATA_W-1:0] dmem_rdata;
    logic [DATA_W-1:0] result;
    logic              result_valid;
    logic              done;
    logic [CNT_W-1:0]  retired;

    logic [9:0]        imem [0:255];
    logic [DATA_W-1:0] dmem [0:15];
    assign imem_rdata = imem[imem_addr];
    assign dmem_rdata = dmem[dmem_addr];

    cpu_pipe_param #(.DATA_W(DATA_W), .PC_W(PC_W), .CNT_W(CNT_W)) u_dut (
        .clock(clock), .reset(reset),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_we(dmem_we), .dmem_rdata(dmem_rdata),
        .result(result), .result_valid(result_valid), .done(done), .retired(retired)
    );

    // Narrow-PC core: only its fetch address is observed
    logic [3:0]        imem4_addr;
    logic [9:0]        imem4_rdata;
    logic [9:0]        imem4 [0:15];
    logic [3:0]        d4_addr;
    logic [DATA_W-1:0] d4_wdata, d4_result;
    logic              d4_we, d4_rv, d4_done;
    logic [CNT_W-1:0]  d4_retired;
    assign imem4_rdata = imem4[imem4_addr];

    cpu_pipe_param #(.DATA_W(DATA_W), .PC_W(4), .CNT_W(CNT_W)) u_dut4 (
        .clock(clock), .reset(reset),
        .imem_addr(imem4_addr), .imem_rdata(imem4_rdata),
        .dmem_addr(d4_addr), .dmem_wdata(d4_wdata), .dmem_we(d4_we), .dmem_rdata('0),
        .result(d4_result), .result_valid(d4_rv), .done(d4_done), .retired(d4_retired)
    );

    int checks = 0;
    int failures = 0;

    // Observations recorded by run_prog
    logic [DATA_W-1:0] res [0:63];
    int                res_cyc [0:63];
    int                n_res, done_cyc, we_cnt, we_cyc, post_bad;
    logic [3:0]        we_addr;
    logic [DATA_W-1:0] we_dat;
    logic [3:0]        pc4 [0:63];

    function automatic logic [9:0] ir(input logic [2:0] op, input logic [2:0] rd, input logic [3:0] lo);
        return {op, rd, lo};
    endfunction

    function automatic logic [9:0] ib(input logic [2:0] op, input logic [6:0] off);
        return {op, off};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) imem[i] = HALT;
        for (int i = 0; i < 16; i++) dmem[i] = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
    endtask

    // Releases reset and records write-backs, stores and done; applies stores to dmem before the edge
    task automatic run_prog(input int min_cyc);
        n_res = 0; done_cyc = -1; we_cnt = 0; we_cyc = -1; post_bad = 0;
        we_addr = '0; we_dat = '0;
        reset = 1'b0;
        for (int c = 0; c < 400; c++) begin
            #1;
            if (c < 64) pc4[c] = imem4_addr;
            if (result_valid) begin
                if (n_res < 64) begin
                    res[n_res] = result;
                    res_cyc[n_res] = c;
                end
                n_res++;
            end
            if (dmem_we) begin
                we_cnt++;
                we_addr = dmem_addr;
                we_dat = dmem_wdata;
                we_cyc = c;
                dmem[dmem_addr] = dmem_wdata;
            end
            if (done && (result_valid || dmem_we)) post_bad++;
            if (done && done_cyc < 0) done_cyc = c;
            if (done_cyc >= 0 && c >= done_cyc + 3 && c >= min_cyc) break;
            @(negedge clock);
        end
    endtask

    task automatic load_fwd_prog();
        clear_mem();
        dmem[0] = 10'd8;
        dmem[1] = 10'd5;
        imem[0] = ir(3'b000, 3'd2, 4'd0);   // LD R2,[0]
        imem[1] = ir(3'b000, 3'd3, 4'd1);   // LD R3,[1]
        imem[2] = ir(3'b011, 3'd2, 4'd3);   // ADD R2,R3
        imem[3] = ir(3'b010, 3'd2, 4'hF);   // ADDI R2,-1
        imem[4] = HALT;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        if (imem_addr !== 8'd0) begin failures++; $display("FAIL rst_pc got=%0d exp=0", imem_addr); end
        checks++;
        if (result !== 10'd0 || result_valid !== 1'b0) begin failures++; $display("FAIL rst_result got=%0d/%0b exp=0/0", result, result_valid); end
        checks++;
        if (done !== 1'b0 || retired !== 16'd0) begin failures++; $display("FAIL rst_status got done=%0b retired=%0d exp=0/0", done, retired); end
        checks++;
        if (dmem_we !== 1'b0) begin failures++; $display("FAIL rst_we got=%0b exp=0", dmem_we); end
        checks++;
    endtask

    task automatic test_forwarding();
        logic [DATA_W-1:0] exp_r [4];
        exp_r[0] = 10'd8; exp_r[1] = 10'd5; exp_r[2] = 10'd13; exp_r[3] = 10'd12;
        load_fwd_prog();
        do_reset();
        run_prog(0);
        if (n_res !== 4) begin failures++; $display("FAIL fwd_count got=%0d exp=4", n_res); end
        checks++;
        for (int i = 0; i < 4; i++) begin
            if (res[i] !== exp_r[i] || res_cyc[i] !== 3 + i) begin
                failures++;
                $display("FAIL fwd_res%0d got=%0d@%0d exp=%0d@%0d", i, res[i], res_cyc[i], exp_r[i], 3 + i);
            end
            checks++;
        end
        if (retired !== 16'd4) begin failures++; $display("FAIL fwd_retired got=%0d exp=4", retired); end
        checks++;
        if (done_cyc !== 8) begin failures++; $display("FAIL fwd_done_cycle got=%0d exp=8", done_cyc); end
        checks++;
        if (post_bad !== 0 || done !== 1'b1) begin failures++; $display("FAIL fwd_after_done got=%0d/%0b exp=0/1", post_bad, done); end
        checks++;
    endtask

    task automatic test_store_load();
        clear_mem();
        imem[0] = ir(3'b010, 3'd4, 4'd7);   // ADDI R4,7
        imem[1] = ir(3'b001, 3'd4, 4'd3);   // ST R4,[3]
        imem[2] = ir(3'b000, 3'd5, 4'd3);   // LD R5,[3]
        imem[3] = HALT;
        do_reset();
        run_prog(0);
        if (we_cnt !== 1 || we_addr !== 4'd3 || we_dat !== 10'd7 || we_cyc !== 3) begin
            failures++;
            $display("FAIL st_pulse got=n%0d a%0d d%0d c%0d exp=n1 a3 d7 c3", we_cnt, we_addr, we_dat, we_cyc);
        end
        checks++;
        if (n_res !== 2 || res[0] !== 10'd7 || res[1] !== 10'd7) begin
            failures++;
            $display("FAIL ld_result got=n%0d %0d,%0d exp=n2 7,7", n_res, res[0], res[1]);
        end
        checks++;
        if (dmem[3] !== 10'd7 || retired !== 16'd3) begin
            failures++;
            $display("FAIL st_mem got=%0d retired=%0d exp=7 retired=3", dmem[3], retired);
        end
        checks++;
    endtask

    task automatic test_branch_taken();
        logic [DATA_W-1:0] exp_r [4];
        exp_r[0] = 10'd8; exp_r[1] = 10'd5; exp_r[2] = 10'd1; exp_r[3] = 10'd2;
        clear_mem();
        dmem[0] = 10'd8;
        dmem[1] = 10'd5;
        imem[0] = ir(3'b000, 3'd2, 4'd0);   // LD R2,[0]
        imem[1] = ir(3'b000, 3'd3, 4'd1);   // LD R3,[1]
        imem[2] = ir(3'b100, 3'd2, 4'd3);   // GRT R2,R3
        imem[3] = ib(3'b110, 7'd1);         // BNE1 +1 -> 5
        imem[4] = ir(3'b010, 3'd6, 4'd1);   // ADDI R6,1 (skipped)
        imem[5] = ir(3'b010, 3'd6, 4'd2);   // ADDI R6,2
        imem[6] = HALT;
        do_reset();
        run_prog(0);
        if (n_res !== 4) begin failures++; $display("FAIL br_count got=%0d exp=4", n_res); end
        checks++;
        for (int i = 0; i < 4; i++) begin
            if (res[i] !== exp_r[i]) begin failures++; $display("FAIL br_res%0d got=%0d exp=%0d", i, res[i], exp_r[i]); end
            checks++;
        end
        if (res_cyc[3] !== 9 || done_cyc !== 11) begin
            failures++;
            $display("FAIL br_bubbles got=wb%0d done%0d exp=wb9 done11", res_cyc[3], done_cyc);
        end
        checks++;
        if (retired !== 16'd5) begin failures++; $display("FAIL br_retired got=%0d exp=5", retired); end
        checks++;
    endtask

    task automatic test_loop();
        logic [DATA_W-1:0] exp_r [10];
        exp_r[0] = 10'd3; exp_r[1] = 10'd1; exp_r[2] = 10'd2; exp_r[3] = 10'd1; exp_r[4] = 10'd2;
        exp_r[5] = 10'd1; exp_r[6] = 10'd1; exp_r[7] = 10'd3; exp_r[8] = 10'd0; exp_r[9] = 10'd0;
        clear_mem();
        imem[0] = ir(3'b010, 3'd1, 4'd3);   // ADDI R1,3
        imem[1] = ir(3'b010, 3'd5, 4'd1);   // ADDI R5,1 (loop body)
        imem[2] = ir(3'b010, 3'd1, 4'hF);   // ADDI R1,-1
        imem[3] = ir(3'b100, 3'd1, 4'd7);   // GRT R1,R7
        imem[4] = ib(3'b110, 7'h7C);        // BNE1 -4 -> 1
        imem[5] = HALT;
        do_reset();
        run_prog(0);
        if (n_res !== 10) begin failures++; $display("FAIL loop_count got=%0d exp=10", n_res); end
        checks++;
        for (int i = 0; i < 10; i++) begin
            if (res[i] !== exp_r[i]) begin failures++; $display("FAIL loop_res%0d got=%0d exp=%0d", i, res[i], exp_r[i]); end
            checks++;
        end
        if (retired !== 16'd13 || done_cyc !== 21) begin
            failures++;
            $display("FAIL loop_timing got=retired%0d done%0d exp=retired13 done21", retired, done_cyc);
        end
        checks++;
    endtask

    task automatic test_wrap();
        logic [3:0] exp_pc [5];
        exp_pc[0] = 4'd15; exp_pc[1] = 4'd0; exp_pc[2] = 4'd1; exp_pc[3] = 4'd0; exp_pc[4] = 4'd1;
        clear_mem();
        dmem[2] = 10'd1023;
        imem[0] = ir(3'b000, 3'd1, 4'd2);   // LD R1,[2]
        imem[1] = ir(3'b010, 3'd1, 4'd1);   // ADDI R1,1
        imem[2] = HALT;
        do_reset();
        run_prog(24);
        if (n_res !== 2 || res[0] !== 10'd1023 || res[1] !== 10'd0) begin
            failures++;
            $display("FAIL data_wrap got=n%0d %0d,%0d exp=n2 1023,0", n_res, res[0], res[1]);
        end
        checks++;
        for (int i = 0; i < 5; i++) begin
            if (pc4[15 + i] !== exp_pc[i]) begin
                failures++;
                $display("FAIL pc_wrap_c%0d got=%0d exp=%0d", 15 + i, pc4[15 + i], exp_pc[i]);
            end
            checks++;
        end
    endtask

    task automatic test_reset_mid();
        logic [DATA_W-1:0] exp_r [4];
        exp_r[0] = 10'd8; exp_r[1] = 10'd5; exp_r[2] = 10'd13; exp_r[3] = 10'd12;
        load_fwd_prog();
        do_reset();
        reset = 1'b0;
        repeat (4) @(negedge clock);
        reset = 1'b1;
        #1;
        if (dmem_we !== 1'b0 || result_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_rst_cycle got=we%0b rv%0b exp=we0 rv0", dmem_we, result_valid);
        end
        checks++;
        @(negedge clock);
        #1;
        if (imem_addr !== 8'd0 || result !== 10'd0 || retired !== 16'd0 || result_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_rst_after got=pc%0d r%0d ret%0d rv%0b exp=pc0 r0 ret0 rv0", imem_addr, result, retired, result_valid);
        end
        checks++;
        run_prog(0);
        for (int i = 0; i < 4; i++) begin
            if (res[i] !== exp_r[i]) begin failures++; $display("FAIL mid_rerun_res%0d got=%0d exp=%0d", i, res[i], exp_r[i]); end
            checks++;
        end
        if (n_res !== 4 || retired !== 16'd4 || done_cyc !== 8) begin
            failures++;
            $display("FAIL mid_rerun_end got=n%0d ret%0d done%0d exp=n4 ret4 done8", n_res, retired, done_cyc);
        end
        checks++;
    endtask

    initial begin
        for (int i = 0; i < 15; i++) imem4[i] = ir(3'b010, 3'd7, 4'd0);  // ADDI R7,0
        imem4[15] = ib(3'b101, 7'd0);                                    // BEQZ +0 -> wraps to 0
        clear_mem();
        test_reset();
        test_forwarding();
        test_store_load();
        test_branch_taken();
        test_loop();
        test_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
